// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM stage: widths, opcode encodings, stall levels.
// Latency: n/a (declarations and pure helper functions only).
// Backpressure: n/a.
package mem_access_pkg;

  localparam int RegLen     = 32;
  localparam int RegAddrLen = 5;
  localparam int OpTypeLen  = 3;
  localparam int OpLen      = 6;

  localparam logic [RegLen-1:0] ZeroWord = '0;
  localparam logic Enable  = 1'b1;
  localparam logic Disable = 1'b0;

  // Stall levels understood by pipeline control
  localparam logic [1:0] StallNone = 2'd0;
  localparam logic [1:0] StallIf   = 2'd1;
  localparam logic [1:0] StallAll  = 2'd2;

  // Operation classes
  localparam logic [OpTypeLen-1:0] OPT_NOP    = 3'd0;
  localparam logic [OpTypeLen-1:0] OPT_ALU    = 3'd1;
  localparam logic [OpTypeLen-1:0] OPT_LUI    = 3'd2;
  localparam logic [OpTypeLen-1:0] OPT_JUMP   = 3'd3;
  localparam logic [OpTypeLen-1:0] OPT_BRANCH = 3'd4;
  localparam logic [OpTypeLen-1:0] OPT_LOAD   = 3'd5;
  localparam logic [OpTypeLen-1:0] OPT_STORE  = 3'd6;

  // Operation names
  localparam logic [OpLen-1:0] OP_NOP = 6'h00;
  localparam logic [OpLen-1:0] OP_ADD = 6'h01;
  localparam logic [OpLen-1:0] OP_SUB = 6'h02;
  localparam logic [OpLen-1:0] OP_LB  = 6'h10;
  localparam logic [OpLen-1:0] OP_LH  = 6'h11;
  localparam logic [OpLen-1:0] OP_LW  = 6'h12;
  localparam logic [OpLen-1:0] OP_LBU = 6'h13;
  localparam logic [OpLen-1:0] OP_LHU = 6'h14;
  localparam logic [OpLen-1:0] OP_SB  = 6'h18;
  localparam logic [OpLen-1:0] OP_SH  = 6'h19;
  localparam logic [OpLen-1:0] OP_SW  = 6'h1A;

  function automatic logic is_load(input logic [OpLen-1:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic is_store(input logic [OpLen-1:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic is_mem(input logic [OpLen-1:0] op);
    return is_load(op) || is_store(op);
  endfunction

  // Bytes moved by a memory op; 0 for anything else
  function automatic logic [2:0] op_nbytes(input logic [OpLen-1:0] op);
    logic [2:0] n;
    case (op)
      OP_LB, OP_LBU, OP_SB: n = 3'd1;
      OP_LH, OP_LHU, OP_SH: n = 3'd2;
      OP_LW, OP_SW:         n = 3'd4;
      default:              n = 3'd0;
    endcase
    return n;
  endfunction

  // Classes that never produce a register result
  function automatic logic writes_rd(input logic [OpTypeLen-1:0] t);
    return (t != OPT_NOP) && (t != OPT_BRANCH) && (t != OPT_STORE);
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Extends the assembled little-endian load buffer to a full register word.
// Latency: combinational.
// Backpressure: none.
module mem_load_ext
  import mem_access_pkg::*;
#(
  parameter int XLEN = RegLen
) (
  input  logic [XLEN-1:0]  ld_buf,
  input  logic [OpLen-1:0] opname,
  output logic [XLEN-1:0]  ext
);

  // Sign/zero extension selected by load width and signedness
  always_comb begin
    ext = ld_buf;
    case (opname)
      OP_LB:  ext = {{(XLEN-8){ld_buf[7]}}, ld_buf[7:0]};
      OP_LH:  ext = {{(XLEN-16){ld_buf[15]}}, ld_buf[15:0]};
      OP_LBU: ext = {{(XLEN-8){1'b0}}, ld_buf[7:0]};
      OP_LHU: ext = {{(XLEN-16){1'b0}}, ld_buf[15:0]};
      default: ext = ld_buf;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM stage: ALU results pass through, loads/stores run byte-serial RAM transactions.
// Latency: ALU 0 cycles; loads nbytes+2, stores nbytes+1 cycles with full grant.
// Backpressure: stall_req freezes the pipeline; mem_gnt=0 pauses issue; rdy=0 freezes all.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int XLEN    = RegLen,
  parameter int RADDR_W = RegAddrLen
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic [OpTypeLen-1:0] optype,
  input  logic [OpLen-1:0]     opname,
  input  logic [RADDR_W-1:0]   ex_rd_addr,
  input  logic [XLEN-1:0]      ex_rd_data,
  input  logic [XLEN-1:0]      ex_s_data,
  input  logic                 mem_gnt,
  input  logic [7:0]           mem_din,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [XLEN-1:0]      mem_addr,
  output logic [7:0]           mem_dout,
  output logic                 stall_req,
  output logic [RADDR_W-1:0]   wb_rd_addr,
  output logic [XLEN-1:0]      wb_rd_data,
  output logic                 wb_we
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state;
  logic [XLEN-1:0]    addr_q;
  logic [XLEN-1:0]    sdata_q;
  logic [XLEN-1:0]    ld_buf;
  logic [RADDR_W-1:0] rd_q;
  logic [OpLen-1:0]   op_q;
  logic [2:0]         nbytes_q;
  logic [2:0]         issue_cnt;
  logic [2:0]         recv_cnt;
  logic               store_q;
  logic               pend_q;     // a read was issued last active cycle; its byte is on mem_din

  logic               mem_op;
  logic               issue;
  logic               capture;
  logic               done_nxt;
  logic [XLEN-1:0]    ld_ext;

  // Values the outputs take while running; copied into the hold registers each active cycle
  logic               l_we, l_stall, l_wbwe;
  logic [XLEN-1:0]    l_addr, l_data;
  logic [7:0]         l_dout;
  logic [RADDR_W-1:0] l_rd;
  logic               h_we, h_stall, h_wbwe;
  logic [XLEN-1:0]    h_addr, h_data;
  logic [7:0]         h_dout;
  logic [RADDR_W-1:0] h_rd;

  assign mem_op = is_mem(opname);

  // Per-cycle handshake decisions for the byte engine
  always_comb begin
    issue    = rdy && (state == S_BUSY) && (issue_cnt < nbytes_q) && mem_gnt;
    capture  = rdy && (state == S_BUSY) && pend_q;
    done_nxt = store_q ? (issue && ((issue_cnt + 3'd1) == nbytes_q))
                       : (capture && ((recv_cnt + 3'd1) == nbytes_q));
  end

  mem_load_ext #(.XLEN(XLEN)) u_ext (
    .ld_buf (ld_buf),
    .opname (op_q),
    .ext    (ld_ext)
  );

  // Transaction FSM: latch on accept, issue/capture bytes, one DONE cycle for write-back.
  // Reads are pipelined one deep; the RAM keeps its last read byte while no new read is
  // issued, so a byte pending across a rdy=0 freeze is still valid when capture resumes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      addr_q    <= '0;
      sdata_q   <= '0;
      ld_buf    <= '0;
      rd_q      <= '0;
      op_q      <= '0;
      nbytes_q  <= '0;
      issue_cnt <= '0;
      recv_cnt  <= '0;
      store_q   <= 1'b0;
      pend_q    <= 1'b0;
    end else if (rdy) begin
      case (state)
        S_IDLE: begin
          if (mem_op) begin
            addr_q    <= ex_rd_data;
            sdata_q   <= ex_s_data;
            rd_q      <= ex_rd_addr;
            op_q      <= opname;
            nbytes_q  <= op_nbytes(opname);
            store_q   <= is_store(opname);
            issue_cnt <= '0;
            recv_cnt  <= '0;
            pend_q    <= 1'b0;
            ld_buf    <= '0;
            state     <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (issue) issue_cnt <= issue_cnt + 3'd1;
          pend_q <= issue && !store_q;
          if (capture) begin
            ld_buf[{recv_cnt[1:0], 3'b000} +: 8] <= mem_din;
            recv_cnt <= recv_cnt + 3'd1;
          end
          if (done_nxt) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Running output values by state
  always_comb begin
    l_we    = 1'b0;
    l_addr  = '0;
    l_dout  = '0;
    l_stall = 1'b0;
    l_rd    = '0;
    l_data  = '0;
    l_wbwe  = 1'b0;
    case (state)
      S_IDLE: begin
        if (mem_op) begin
          l_stall = 1'b1;
        end else begin
          l_rd   = ex_rd_addr;
          l_data = ex_rd_data;
          l_wbwe = (ex_rd_addr != '0) && writes_rd(optype);
        end
      end
      S_BUSY: begin
        l_stall = 1'b1;
        l_we    = store_q;
        l_addr  = addr_q + XLEN'(issue_cnt);
        l_dout  = sdata_q[{issue_cnt[1:0], 3'b000} +: 8];
      end
      S_DONE: begin
        l_rd   = rd_q;
        l_data = store_q ? '0 : ld_ext;
        l_wbwe = !store_q && (rd_q != '0);
      end
      default: ;
    endcase
  end

  // Last active-cycle outputs, replayed while rdy is low
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_we    <= 1'b0;
      h_addr  <= '0;
      h_dout  <= '0;
      h_stall <= 1'b0;
      h_rd    <= '0;
      h_data  <= '0;
      h_wbwe  <= 1'b0;
    end else if (rdy) begin
      h_we    <= l_we;
      h_addr  <= l_addr;
      h_dout  <= l_dout;
      h_stall <= l_stall;
      h_rd    <= l_rd;
      h_data  <= l_data;
      h_wbwe  <= l_wbwe;
    end
  end

  // Output select: forced zero in reset, frozen when rdy is low, live otherwise
  always_comb begin
    if (!rst) begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_dout   = '0;
      stall_req  = 1'b0;
      wb_rd_addr = '0;
      wb_rd_data = '0;
      wb_we      = 1'b0;
    end else if (!rdy) begin
      mem_req    = 1'b0;
      mem_we     = h_we;
      mem_addr   = h_addr;
      mem_dout   = h_dout;
      stall_req  = h_stall;
      wb_rd_addr = h_rd;
      wb_rd_data = h_data;
      wb_we      = h_wbwe;
    end else begin
      mem_req    = issue;
      mem_we     = l_we;
      mem_addr   = l_addr;
      mem_dout   = l_dout;
      stall_req  = l_stall;
      wb_rd_addr = l_rd;
      wb_rd_data = l_data;
      wb_we      = l_wbwe;
    end
  end

endmodule
